// File: rtl/cnn_pkg.sv
// Shared constants, state encoding and helpers for the CNN frame scheduler.
// Image geometry lives here so the scheduler and window generator always agree.
package cnn_pkg;

    localparam int IMG_W        = 28;
    localparam int IMG_H        = 28;
    localparam int K            = 3;
    localparam int PIX_PER_BEAT = 8;
    localparam int FRAME_PIX    = IMG_W * IMG_H;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CONV,
        WAIT_TX
    } sched_state_t;

    // Bottom-right pixel of the first (top-left) window.
    function automatic int unsigned first_rd_addr();
        return (K - 1) * IMG_W + (K - 1);
    endfunction

endpackage

// File: rtl/cnn_win_addr_gen.sv
// Window column/row counters and the bottom-right read address of the current
// 3x3 window; steps one pixel per advance and skips K-1 pixels at row end.
module cnn_win_addr_gen
    import cnn_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_advance,
    input  logic              i_clear,
    output logic [ADDR_W-1:0] o_addr_rd,
    output logic [4:0]        o_win_col,
    output logic [4:0]        o_win_row,
    output logic              o_last_win
);

    localparam logic [ADDR_W-1:0] RD_INIT  = ADDR_W'(first_rd_addr());
    localparam logic [ADDR_W-1:0] ROW_SKIP = ADDR_W'(K);
    localparam logic [4:0]        COL_MAX  = 5'(IMG_W - K);
    localparam logic [4:0]        ROW_MAX  = 5'(IMG_H - K);

    logic [ADDR_W-1:0] r_addr_rd;
    logic [4:0]        r_win_col;
    logic [4:0]        r_win_row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_rd <= RD_INIT;
            r_win_col <= '0;
            r_win_row <= '0;
        end else if (i_clear) begin
            r_addr_rd <= RD_INIT;
            r_win_col <= '0;
            r_win_row <= '0;
        end else if (i_advance) begin
            if (r_win_col < COL_MAX) begin
                r_win_col <= r_win_col + 5'd1;
                r_addr_rd <= r_addr_rd + ADDR_W'(1);
            end else begin
                r_win_col <= '0;
                r_win_row <= r_win_row + 5'd1;
                r_addr_rd <= r_addr_rd + ROW_SKIP;
            end
        end
    end

    assign o_addr_rd  = r_addr_rd;
    assign o_win_col  = r_win_col;
    assign o_win_row  = r_win_row;
    assign o_last_win = (r_win_row == ROW_MAX) && (r_win_col == COL_MAX);

endmodule

// File: rtl/cnn_frame_sched.sv
// Frame scheduler: tracks the RAM write pointer, issues core starts only once a
// window's last pixel has landed, and sequences frame load/convolve/turnaround.
module cnn_frame_sched
    import cnn_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic              core_ack,
    input  logic              tx_done,
    output logic [ADDR_W-1:0] addr_wr,
    output logic [ADDR_W-1:0] addr_rd,
    output logic              strt,
    output logic [4:0]        win_col,
    output logic [4:0]        win_row,
    output logic              frame_busy,
    output logic              frame_done,
    output logic              ovf
);

    localparam logic [ADDR_W-1:0] FRAME_A = ADDR_W'(FRAME_PIX);
    localparam logic [ADDR_W-1:0] BEAT_A  = ADDR_W'(PIX_PER_BEAT);

    sched_state_t      r_state;
    logic [ADDR_W-1:0] r_addr_wr;
    logic              r_ovf;
    logic              r_frame_done;

    logic              w_active;
    logic              w_strt;
    logic              w_ack;
    logic              w_last_win;
    logic              w_final_ack;
    logic              w_accept;
    logic              w_reject;
    logic [ADDR_W-1:0] w_addr_rd;

    assign w_active    = (r_state == LOAD) || (r_state == CONV);
    assign w_strt      = w_active && (w_addr_rd < r_addr_wr);
    assign w_ack       = core_ack && w_strt && !tx_done;
    assign w_final_ack = w_ack && w_last_win;

    // A beat is counted only while a frame can still absorb it; otherwise it is flagged.
    assign w_accept = rx_rdy && !tx_done && (r_state != WAIT_TX) && (r_addr_wr < FRAME_A);
    assign w_reject = rx_rdy && !tx_done && ((r_state == WAIT_TX) || (r_addr_wr >= FRAME_A));

    cnn_win_addr_gen #(
        .ADDR_W(ADDR_W)
    ) u_win_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_advance (w_ack && !w_last_win),
        .i_clear   (tx_done),
        .o_addr_rd (w_addr_rd),
        .o_win_col (win_col),
        .o_win_row (win_row),
        .o_last_win(w_last_win)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_addr_wr    <= '0;
            r_ovf        <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (tx_done) begin
            // A byte landing with tx_done opens the next frame immediately.
            r_state      <= rx_rdy ? LOAD : IDLE;
            r_addr_wr    <= rx_rdy ? BEAT_A : '0;
            r_ovf        <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_final_ack;
            if (w_accept) begin
                r_addr_wr <= r_addr_wr + BEAT_A;
            end
            if (w_reject) begin
                r_ovf <= 1'b1;
            end
            case (r_state)
                IDLE:    if (rx_rdy) r_state <= LOAD;
                LOAD:    if (w_final_ack) r_state <= WAIT_TX;
                         else if (w_strt) r_state <= CONV;
                CONV:    if (w_final_ack) r_state <= WAIT_TX;
                WAIT_TX: r_state <= WAIT_TX;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign addr_wr    = r_addr_wr;
    assign addr_rd    = w_addr_rd;
    assign strt       = w_strt;
    assign frame_busy = w_active;
    assign frame_done = r_frame_done;
    assign ovf        = r_ovf;

endmodule
